ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the pipelined RISC-V core, directly downstream of the ID/EX register. Each cycle it takes one decoded instruction and selects forwarded or register operands. It computes the one-hot ALU operation, resolves jumps and registers the result into the EX/MEM boundary. It also owns the two-cycle squash of younger instructions after a taken jump.

## Interface
No parameters; datapath fixed at 32 bits, register addresses at 5 bits.
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- skip  in  1  hold: stage state frozen while 1
- rd_addr_in  in  5  destination register
- rs1_in, rs2_in  in  32  register-file operands
- imm_in  in  32  sign-extended immediate
- pc_in  in  32  instruction address
- writeback_en_in, writeback_from_mem_in  in  1  writeback controls, passed through
- alu_rs2_reg_in  in  1  1: operand B from rs2, 0: from imm
- add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in, eq_en_in  in  1  one-hot ALU select
- skip_instr_in  in  1  instruction is a bubble
- rs1_take_prev1_in, rs2_take_prev1_in  in  1  forward previous EX result
- jump_on_alu_true_in, jump_always_in  in  1  jump controls
- rd_addr_out  out  5  registered rd
- alu_result_out  out  32  registered ALU result, also forwarding source
- store_data_out  out  32  registered operand-B-register value (rs2 after forwarding)
- writeback_en_out, writeback_from_mem_out  out  1  registered writeback controls
- skip_instr_out  out  1  registered bubble flag
- jump_taken_out  out  1  one-cycle redirect pulse
- jump_target_out  out  32  redirect address, valid with jump_taken_out
- squash_out  out  1  younger instructions in IF/ID must be discarded

## Operation
- Operand A = rs1_take_prev1_in ? alu_result_out : rs1_in.
- Operand rs2v = rs2_take_prev1_in ? alu_result_out : rs2_in.
- Operand B = alu_rs2_reg_in ? rs2v : imm_in.
- ALU: add A+B, sub A-B, both mod 2^32 with carry discarded. xor/or/and bitwise. eq = {31'b0, A==B}.
- Select is one-hot. Zero selects gives result 0. Multiple selects give OR of the selected results; decode never produces this.
- Forwarding from alu_result_out is valid only for ALU producers. Load-use hazards are stalled by decode and never reach this stage.
- Effective bubble: eff_skip = skip_instr_in | squash_out.
- taken = !eff_skip & (jump_always_in | (jump_on_alu_true_in & result!=0)).
- Target = pc_in + imm_in mod 2^32.
- Squash counter, 2 bits:
  - loaded with 2 on a taken jump,
  - otherwise decrements toward 0 on each non-hold cycle,
  - squash_out = (count != 0).
- On eff_skip, registered outputs take:
  - writeback_en_out=0
  - writeback_from_mem_out=0
  - skip_instr_out=1
  - rd_addr_out=0
  - alu_result_out unchanged, so the forwarding value survives the bubble.

## Timing
- Priority: rst > skip (hold) > normal update.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- jump_taken_out is 1 for exactly the cycle after a taken jump is sampled. It is cleared on every other edge, including hold edges, so a redirect is never issued twice. jump_target_out holds its value until the next taken jump.
- squash_out rises in the same cycle as jump_taken_out and stays high for 2 non-hold cycles. During those cycles the instructions arriving from ID/EX are treated as bubbles.
- A jump arriving while squash_out=1 is itself squashed; the counter is not reloaded.
- Hold: all outputs except jump_taken_out keep their value, and the squash counter does not count.
- Reset values, asserted immediately on rst rising:
  - rd_addr_out=0
  - alu_result_out=0
  - store_data_out=0
  - writeback_en_out=1 (nop writes x0)
  - writeback_from_mem_out=0
  - skip_instr_out=0
  - jump_taken_out=0
  - jump_target_out=0
  - squash_out=0, counter=0
- Reset mid-squash clears the counter.
- Release is synchronous to the next clk edge.

## Test plan
- add: rs1=5, rs2=7, alu_rs2_reg=1, add_en → alu_result_out=12, rd, writeback_en=1 one cycle later. sub 3-5 → 0xFFFFFFFE.
- Forwarding: instr1 add x1=10+0; instr2 add rs1_take_prev1=1, imm=3, alu_rs2_reg=0 → result 13. Insert a bubble between the two → still 13.
- eq jump taken: rs1=rs2=9, eq_en, jump_on_alu_true, pc=0x100, imm=0x20 → jump_taken_out pulse, target 0x120, squash_out high 2 cycles, next two instrs give writeback_en_out=0 and skip_instr_out=1. Repeat with rs2=8 → no jump, no squash.
- Jump inside squash window: jump_always on the first instruction after a taken jump → no second pulse, squash_out drops after 2 cycles.
- Hold: skip=1 for 3 cycles right after a taken jump → jump_taken_out low after 1 cycle, other outputs frozen, squash_out remains high until 2 non-hold cycles have elapsed.
- Async reset mid-squash: pulse rst between edges → outputs at reset values immediately (writeback_en_out=1, squash_out=0), and normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, one-hot ALU, jump resolution and EX/MEM register.
// Owns the two-cycle squash of younger instructions following a taken jump.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        skip,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] pc_in,
    input  logic        writeback_en_in,
    input  logic        writeback_from_mem_in,
    input  logic        alu_rs2_reg_in,
    input  logic        add_en_in,
    input  logic        sub_en_in,
    input  logic        xor_en_in,
    input  logic        or_en_in,
    input  logic        and_en_in,
    input  logic        eq_en_in,
    input  logic        skip_instr_in,
    input  logic        rs1_take_prev1_in,
    input  logic        rs2_take_prev1_in,
    input  logic        jump_on_alu_true_in,
    input  logic        jump_always_in,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic        writeback_en_out,
    output logic        writeback_from_mem_out,
    output logic        skip_instr_out,
    output logic        jump_taken_out,
    output logic [31:0] jump_target_out,
    output logic        squash_out
);

    logic [31:0] op_a;
    logic [31:0] rs2_val;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic [31:0] jump_target;
    logic        eff_skip;
    logic        taken;
    logic [1:0]  squash_cnt;
    logic [1:0]  squash_cnt_nxt;

    assign op_a    = rs1_take_prev1_in ? alu_result_out : rs1_in;
    assign rs2_val = rs2_take_prev1_in ? alu_result_out : rs2_in;
    assign op_b    = alu_rs2_reg_in ? rs2_val : imm_in;

    // Selected results are ORed so an empty select yields zero.
    always_comb begin
        alu_result = 32'd0;
        if (add_en_in) alu_result = alu_result | (op_a + op_b);
        if (sub_en_in) alu_result = alu_result | (op_a - op_b);
        if (xor_en_in) alu_result = alu_result | (op_a ^ op_b);
        if (or_en_in)  alu_result = alu_result | (op_a | op_b);
        if (and_en_in) alu_result = alu_result | (op_a & op_b);
        if (eq_en_in)  alu_result = alu_result | {31'd0, op_a == op_b};
    end

    assign squash_out  = (squash_cnt != 2'd0);
    assign eff_skip    = skip_instr_in | squash_out;
    assign taken       = !eff_skip &&
                         (jump_always_in || (jump_on_alu_true_in && (alu_result != 32'd0)));
    assign jump_target = pc_in + imm_in;

    // A jump inside the squash window is itself a bubble, so it can never reload the counter.
    always_comb begin
        squash_cnt_nxt = squash_cnt;
        if (taken)
            squash_cnt_nxt = 2'd2;
        else if (squash_cnt != 2'd0)
            squash_cnt_nxt = squash_cnt - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_cnt      <= 2'd0;
            jump_taken_out  <= 1'b0;
            jump_target_out <= 32'd0;
        end else if (skip) begin
            jump_taken_out  <= 1'b0;
        end else begin
            squash_cnt     <= squash_cnt_nxt;
            jump_taken_out <= taken;
            if (taken)
                jump_target_out <= jump_target;
        end
    end

    // Bubbles leave alu_result_out untouched so a forwarding value survives them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr_out            <= 5'd0;
            alu_result_out         <= 32'd0;
            store_data_out         <= 32'd0;
            writeback_en_out       <= 1'b1;
            writeback_from_mem_out <= 1'b0;
            skip_instr_out         <= 1'b0;
        end else if (!skip) begin
            if (eff_skip) begin
                rd_addr_out            <= 5'd0;
                writeback_en_out       <= 1'b0;
                writeback_from_mem_out <= 1'b0;
                skip_instr_out         <= 1'b1;
            end else begin
                rd_addr_out            <= rd_addr_in;
                alu_result_out         <= alu_result;
                store_data_out         <= rs2_val;
                writeback_en_out       <= writeback_en_in;
                writeback_from_mem_out <= writeback_from_mem_in;
                skip_instr_out         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, jumps, squash window, hold and async reset.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        skip;
    logic [4:0]  rd_addr_in;
    logic [31:0] rs1_in, rs2_in, imm_in, pc_in;
    logic        writeback_en_in, writeback_from_mem_in, alu_rs2_reg_in;
    logic        add_en_in, sub_en_in, xor_en_in, or_en_in, and_en_in, eq_en_in;
    logic        skip_instr_in, rs1_take_prev1_in, rs2_take_prev1_in;
    logic        jump_on_alu_true_in, jump_always_in;
    logic [4:0]  rd_addr_out;
    logic [31:0] alu_result_out, store_data_out, jump_target_out;
    logic        writeback_en_out, writeback_from_mem_out, skip_instr_out;
    logic        jump_taken_out, squash_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .skip(skip),
        .rd_addr_in(rd_addr_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .imm_in(imm_in), .pc_in(pc_in),
        .writeback_en_in(writeback_en_in), .writeback_from_mem_in(writeback_from_mem_in),
        .alu_rs2_reg_in(alu_rs2_reg_in),
        .add_en_in(add_en_in), .sub_en_in(sub_en_in), .xor_en_in(xor_en_in),
        .or_en_in(or_en_in), .and_en_in(and_en_in), .eq_en_in(eq_en_in),
        .skip_instr_in(skip_instr_in),
        .rs1_take_prev1_in(rs1_take_prev1_in), .rs2_take_prev1_in(rs2_take_prev1_in),
        .jump_on_alu_true_in(jump_on_alu_true_in), .jump_always_in(jump_always_in),
        .rd_addr_out(rd_addr_out), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out),
        .writeback_en_out(writeback_en_out), .writeback_from_mem_out(writeback_from_mem_out),
        .skip_instr_out(skip_instr_out), .jump_taken_out(jump_taken_out),
        .jump_target_out(jump_target_out), .squash_out(squash_out)
    );

    task automatic clear_instr();
        rd_addr_in = 5'd0; rs1_in = 32'd0; rs2_in = 32'd0; imm_in = 32'd0; pc_in = 32'd0;
        writeback_en_in = 1'b0; writeback_from_mem_in = 1'b0; alu_rs2_reg_in = 1'b0;
        add_en_in = 1'b0; sub_en_in = 1'b0; xor_en_in = 1'b0;
        or_en_in = 1'b0; and_en_in = 1'b0; eq_en_in = 1'b0;
        skip_instr_in = 1'b0; rs1_take_prev1_in = 1'b0; rs2_take_prev1_in = 1'b0;
        jump_on_alu_true_in = 1'b0; jump_always_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; skip = 1'b0; clear_instr();
        step(); step();
        checks++; if (writeback_en_out !== 1'b1) begin failures++; $display("FAIL reset_wb_en got=%b exp=1", writeback_en_out); end
        checks++; if (alu_result_out !== 32'd0) begin failures++; $display("FAIL reset_alu got=%h exp=0", alu_result_out); end
        checks++; if ({rd_addr_out, skip_instr_out, jump_taken_out, squash_out, writeback_from_mem_out} !== 9'd0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=0", {rd_addr_out, skip_instr_out, jump_taken_out, squash_out, writeback_from_mem_out}); end
        checks++; if ({store_data_out, jump_target_out} !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {store_data_out, jump_target_out}); end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        clear_instr();
        rs1_in = 32'd5; rs2_in = 32'd7; alu_rs2_reg_in = 1'b1; add_en_in = 1'b1;
        rd_addr_in = 5'd3; writeback_en_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'd12) begin failures++; $display("FAIL add_result got=%h exp=0000000c", alu_result_out); end
        checks++; if (rd_addr_out !== 5'd3 || writeback_en_out !== 1'b1 || skip_instr_out !== 1'b0) begin
            failures++; $display("FAIL add_ctrl got rd=%0d wb=%b sk=%b exp rd=3 wb=1 sk=0", rd_addr_out, writeback_en_out, skip_instr_out); end
        checks++; if (store_data_out !== 32'd7) begin failures++; $display("FAIL add_store got=%h exp=00000007", store_data_out); end
        clear_instr();
        rs1_in = 32'd3; rs2_in = 32'd5; alu_rs2_reg_in = 1'b1; sub_en_in = 1'b1; writeback_en_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_result got=%h exp=fffffffe", alu_result_out); end
        clear_instr();
        rs1_in = 32'h0000_00F0; imm_in = 32'h0000_00FF; xor_en_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'h0000_000F) begin failures++; $display("FAIL xor_imm got=%h exp=0000000f", alu_result_out); end
        clear_instr();
        rs1_in = 32'hF0F0_0000; rs2_in = 32'h0FF0_0001; alu_rs2_reg_in = 1'b1; or_en_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'hFFF0_0001) begin failures++; $display("FAIL or_result got=%h exp=fff00001", alu_result_out); end
        and_en_in = 1'b1; or_en_in = 1'b0;
        step();
        checks++; if (alu_result_out !== 32'h00F0_0000) begin failures++; $display("FAIL and_result got=%h exp=00f00000", alu_result_out); end
        clear_instr();
        rs1_in = 32'd77; writeback_en_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'd0) begin failures++; $display("FAIL no_select got=%h exp=0", alu_result_out); end
    endtask

    task automatic test_forward();
        clear_instr();
        rs1_in = 32'd10; add_en_in = 1'b1; rd_addr_in = 5'd1; writeback_en_in = 1'b1;
        step();
        rs1_in = 32'd999; rs1_take_prev1_in = 1'b1; imm_in = 32'd3; rd_addr_in = 5'd2;
        step();
        checks++; if (alu_result_out !== 32'd13) begin failures++; $display("FAIL fwd_direct got=%0d exp=13", alu_result_out); end
        clear_instr();
        rs1_in = 32'd10; add_en_in = 1'b1; rd_addr_in = 5'd1; writeback_en_in = 1'b1;
        step();
        rs1_in = 32'd55; skip_instr_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'd10 || skip_instr_out !== 1'b1 || writeback_en_out !== 1'b0 || rd_addr_out !== 5'd0) begin
            failures++; $display("FAIL bubble_out got alu=%0d sk=%b wb=%b rd=%0d exp alu=10 sk=1 wb=0 rd=0", alu_result_out, skip_instr_out, writeback_en_out, rd_addr_out); end
        skip_instr_in = 1'b0; rs1_take_prev1_in = 1'b1; imm_in = 32'd3; rd_addr_in = 5'd2;
        step();
        checks++; if (alu_result_out !== 32'd13) begin failures++; $display("FAIL fwd_bubble got=%0d exp=13", alu_result_out); end
        clear_instr();
        rs1_in = 32'd40; rs2_take_prev1_in = 1'b1; rs2_in = 32'd1; alu_rs2_reg_in = 1'b1; sub_en_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'd27 || store_data_out !== 32'd13) begin
            failures++; $display("FAIL fwd_rs2 got alu=%0d st=%0d exp alu=27 st=13", alu_result_out, store_data_out); end
    endtask

    task automatic test_jump();
        clear_instr();
        rs1_in = 32'd9; rs2_in = 32'd9; alu_rs2_reg_in = 1'b1; eq_en_in = 1'b1;
        jump_on_alu_true_in = 1'b1; pc_in = 32'h100; imm_in = 32'h20;
        step();
        checks++; if (jump_taken_out !== 1'b1 || jump_target_out !== 32'h120 || squash_out !== 1'b1) begin
            failures++; $display("FAIL eq_jump got tk=%b tgt=%h sq=%b exp tk=1 tgt=00000120 sq=1", jump_taken_out, jump_target_out, squash_out); end
        clear_instr();
        rs1_in = 32'd1; add_en_in = 1'b1; rd_addr_in = 5'd5; writeback_en_in = 1'b1;
        step();
        checks++; if (jump_taken_out !== 1'b0 || squash_out !== 1'b1 || writeback_en_out !== 1'b0 || skip_instr_out !== 1'b1) begin
            failures++; $display("FAIL squash1 got tk=%b sq=%b wb=%b sk=%b exp tk=0 sq=1 wb=0 sk=1", jump_taken_out, squash_out, writeback_en_out, skip_instr_out); end
        step();
        checks++; if (squash_out !== 1'b0 || writeback_en_out !== 1'b0 || skip_instr_out !== 1'b1 || alu_result_out !== 32'd1) begin
            failures++; $display("FAIL squash2 got sq=%b wb=%b sk=%b alu=%h exp sq=0 wb=0 sk=1 alu=1", squash_out, writeback_en_out, skip_instr_out, alu_result_out); end
        step();
        checks++; if (writeback_en_out !== 1'b1 || skip_instr_out !== 1'b0 || rd_addr_out !== 5'd5) begin
            failures++; $display("FAIL post_squash got wb=%b sk=%b rd=%0d exp wb=1 sk=0 rd=5", writeback_en_out, skip_instr_out, rd_addr_out); end
        clear_instr();
        rs1_in = 32'd9; rs2_in = 32'd8; alu_rs2_reg_in = 1'b1; eq_en_in = 1'b1;
        jump_on_alu_true_in = 1'b1; pc_in = 32'h300; imm_in = 32'h40;
        step();
        checks++; if (jump_taken_out !== 1'b0 || squash_out !== 1'b0 || jump_target_out !== 32'h120 || alu_result_out !== 32'd0) begin
            failures++; $display("FAIL eq_no_jump got tk=%b sq=%b tgt=%h alu=%h exp tk=0 sq=0 tgt=00000120 alu=0", jump_taken_out, squash_out, jump_target_out, alu_result_out); end
    endtask

    task automatic test_jump_in_window();
        clear_instr();
        jump_always_in = 1'b1; pc_in = 32'h200; imm_in = 32'h10;
        step();
        checks++; if (jump_taken_out !== 1'b1 || jump_target_out !== 32'h210) begin
            failures++; $display("FAIL jal_first got tk=%b tgt=%h exp tk=1 tgt=00000210", jump_taken_out, jump_target_out); end
        pc_in = 32'h300; imm_in = 32'h4;
        step();
        checks++; if (jump_taken_out !== 1'b0 || jump_target_out !== 32'h210 || squash_out !== 1'b1) begin
            failures++; $display("FAIL jal_in_window got tk=%b tgt=%h sq=%b exp tk=0 tgt=00000210 sq=1", jump_taken_out, jump_target_out, squash_out); end
        clear_instr();
        step();
        checks++; if (squash_out !== 1'b0 || jump_taken_out !== 1'b0) begin
            failures++; $display("FAIL window_end got sq=%b tk=%b exp sq=0 tk=0", squash_out, jump_taken_out); end
    endtask

    task automatic test_hold();
        clear_instr();
        jump_always_in = 1'b1; pc_in = 32'h400; imm_in = 32'h8;
        rs1_in = 32'd4; alu_rs2_reg_in = 1'b1; rs2_in = 32'd2; add_en_in = 1'b1;
        rd_addr_in = 5'd9; writeback_en_in = 1'b1;
        step();
        checks++; if (jump_taken_out !== 1'b1 || alu_result_out !== 32'd6 || rd_addr_out !== 5'd9) begin
            failures++; $display("FAIL hold_jump got tk=%b alu=%0d rd=%0d exp tk=1 alu=6 rd=9", jump_taken_out, alu_result_out, rd_addr_out); end
        clear_instr();
        skip = 1'b1; rs1_in = 32'd50; add_en_in = 1'b1; rd_addr_in = 5'd7; writeback_en_in = 1'b1;
        step();
        checks++; if (jump_taken_out !== 1'b0 || squash_out !== 1'b1 || alu_result_out !== 32'd6 || rd_addr_out !== 5'd9 || writeback_en_out !== 1'b1) begin
            failures++; $display("FAIL hold_first got tk=%b sq=%b alu=%0d rd=%0d wb=%b exp tk=0 sq=1 alu=6 rd=9 wb=1",
                jump_taken_out, squash_out, alu_result_out, rd_addr_out, writeback_en_out); end
        step(); step();
        checks++; if (squash_out !== 1'b1 || alu_result_out !== 32'd6 || jump_target_out !== 32'h408 || store_data_out !== 32'd2) begin
            failures++; $display("FAIL hold_third got sq=%b alu=%0d tgt=%h st=%0d exp sq=1 alu=6 tgt=00000408 st=2",
                squash_out, alu_result_out, jump_target_out, store_data_out); end
        skip = 1'b0;
        step();
        checks++; if (squash_out !== 1'b1 || writeback_en_out !== 1'b0 || skip_instr_out !== 1'b1) begin
            failures++; $display("FAIL hold_resume1 got sq=%b wb=%b sk=%b exp sq=1 wb=0 sk=1", squash_out, writeback_en_out, skip_instr_out); end
        step();
        checks++; if (squash_out !== 1'b0 || alu_result_out !== 32'd6) begin
            failures++; $display("FAIL hold_resume2 got sq=%b alu=%0d exp sq=0 alu=6", squash_out, alu_result_out); end
        step();
        checks++; if (alu_result_out !== 32'd50 || rd_addr_out !== 5'd7) begin
            failures++; $display("FAIL hold_after got alu=%0d rd=%0d exp alu=50 rd=7", alu_result_out, rd_addr_out); end
    endtask

    task automatic test_async_reset();
        clear_instr();
        jump_always_in = 1'b1; pc_in = 32'h500; imm_in = 32'h4;
        rs1_in = 32'd3; add_en_in = 1'b1; rd_addr_in = 5'd4;
        step();
        clear_instr();
        checks++; if (squash_out !== 1'b1 || writeback_en_out !== 1'b0) begin
            failures++; $display("FAIL pre_reset got sq=%b wb=%b exp sq=1 wb=0", squash_out, writeback_en_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (writeback_en_out !== 1'b1 || squash_out !== 1'b0 || jump_taken_out !== 1'b0 ||
                      alu_result_out !== 32'd0 || jump_target_out !== 32'd0 || rd_addr_out !== 5'd0) begin
            failures++; $display("FAIL async_reset got wb=%b sq=%b tk=%b alu=%h tgt=%h rd=%0d exp wb=1 sq=0 tk=0 alu=0 tgt=0 rd=0",
                writeback_en_out, squash_out, jump_taken_out, alu_result_out, jump_target_out, rd_addr_out); end
        #2 rst = 1'b0;
        rs1_in = 32'd5; rs2_in = 32'd7; alu_rs2_reg_in = 1'b1; add_en_in = 1'b1;
        rd_addr_in = 5'd6; writeback_en_in = 1'b1;
        step();
        checks++; if (alu_result_out !== 32'd12 || rd_addr_out !== 5'd6 || skip_instr_out !== 1'b0 || squash_out !== 1'b0) begin
            failures++; $display("FAIL post_reset got alu=%0d rd=%0d sk=%b sq=%b exp alu=12 rd=6 sk=0 sq=0",
                alu_result_out, rd_addr_out, skip_instr_out, squash_out); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_forward();
        test_jump();
        test_jump_in_window();
        test_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
